// File: rtl/reg_column_pkg.sv
// reg_column_pkg: shared constants and types for the reg_column storage column.
//   DATA_W : width of each stored word
//   ADDR_W : address width
//   DEPTH  : number of words, always 1 << ADDR_W
//   data_t / addr_t : word and address types
package reg_column_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/reg_word.sv
// reg_word: one W-bit storage register with asynchronous active-high clear
// and a synchronous load enable.
// Ports:
//   clk_i  : clock, loads on the rising edge
//   arst_i : asynchronous active-high reset, clears q to 0
//   ld     : load enable, captures d on the rising edge
//   d      : load data
//   q      : stored value
module reg_word #(
  parameter int W = reg_column_pkg::DATA_W
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Word storage: cleared by reset, otherwise loaded only when selected.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      q_r <= {W{1'b0}};
    end else if (ld) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/reg_column.sv
// reg_column: 2**ADDR_W x DATA_W storage column with one synchronous write
// port and a combinational read port sharing the same address.
// Ports:
//   clk_i  : clock, writes occur on the rising edge
//   arst_i : asynchronous active-high reset, clears every word
//   in     : write data
//   addr   : shared read/write address (fully decoded)
//   en_i   : write enable
//   out    : read data, always equal to the word at addr
module reg_column #(
  parameter int DATA_W = reg_column_pkg::DATA_W,
  parameter int ADDR_W = reg_column_pkg::ADDR_W
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [DATA_W-1:0] in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              en_i,
  output logic [DATA_W-1:0] out
);

  import reg_column_pkg::*;

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0]  ld_s;
  logic [DATA_W-1:0] words_s [DEPTH];
  logic [DATA_W-1:0] out_s;

  // One register per address; each loads only when the write decodes to it,
  // so exactly one word changes per enabled edge and the rest hold.
  for (genvar k = 0; k < DEPTH; k++) begin : g_word
    assign ld_s[k] = en_i & (addr == ADDR_W'(k));

    reg_word #(
      .W (DATA_W)
    ) u_word (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .ld     (ld_s[k]),
      .d      (in),
      .q      (words_s[k])
    );
  end

  // Read mux: every addr value selects a real word, so no range guard is needed.
  always_comb begin
    out_s = {DATA_W{1'b0}};
    out_s = words_s[addr];
  end

  assign out = out_s;

endmodule

// File: tb/tb_reg_column.sv
// tb_reg_column: directed, table-driven self-checking bench for reg_column.
module tb_reg_column;
  import reg_column_pkg::*;

  logic  clk;
  logic  clk_run;
  logic  arst;
  data_t din;
  addr_t addr;
  logic  en;
  data_t dout;

  int tests_run;
  int tests_failed;

  data_t model [DEPTH];

  typedef struct {
    logic  en;
    addr_t a;
    data_t d;
    addr_t ca;
    data_t exp;
    string name;
  } vec_t;

  vec_t vecs [12];

  reg_column dut (
    .clk_i  (clk),
    .arst_i (arst),
    .in     (din),
    .addr   (addr),
    .en_i   (en),
    .out    (dout)
  );

  // Free-running clock that can be parked low to hold reset without edges.
  always #5 if (clk_run) clk = ~clk;

  task automatic check(input string name, input data_t act, input data_t exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic read_check(input string name, input addr_t a, input data_t exp);
    addr = a;
    #1;
    check(name, dout, exp);
  endtask

  task automatic do_write(input addr_t a, input data_t d);
    @(negedge clk);
    addr = a;
    din  = d;
    en   = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    model[a] = d;
  endtask

  initial begin
    addr_t a;
    data_t d;
    addr_t ra;

    tests_run    = 0;
    tests_failed = 0;
    clk     = 1'b0;
    clk_run = 1'b1;
    arst    = 1'b1;
    din     = 8'h00;
    addr    = 10'd0;
    en      = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;

    // Vector table: write (if en), then read check address ca.
    vecs[0]  = '{1'b1, 10'd10,   8'h3C, 10'd10,   8'h3C, "basic_wr10"};
    vecs[1]  = '{1'b0, 10'd10,   8'h00, 10'd9,    8'h00, "neighbour9"};
    vecs[2]  = '{1'b0, 10'd10,   8'h00, 10'd11,   8'h00, "neighbour11"};
    vecs[3]  = '{1'b1, 10'd0,    8'h01, 10'd0,    8'h01, "wr_addr0"};
    vecs[4]  = '{1'b1, 10'd1023, 8'h80, 10'd1023, 8'h80, "wr_addr1023"};
    vecs[5]  = '{1'b0, 10'd0,    8'h00, 10'd0,    8'h01, "no_alias0"};
    vecs[6]  = '{1'b0, 10'd0,    8'h00, 10'd1,    8'h00, "no_alias1"};
    vecs[7]  = '{1'b0, 10'd0,    8'h00, 10'd1022, 8'h00, "no_alias1022"};
    vecs[8]  = '{1'b1, 10'd1023, 8'h55, 10'd1023, 8'h55, "overwrite55"};
    vecs[9]  = '{1'b1, 10'd1023, 8'hAA, 10'd1023, 8'hAA, "overwriteAA"};
    vecs[10] = '{1'b1, 10'd512,  8'h5A, 10'd512,  8'h5A, "wr_addr512"};
    vecs[11] = '{1'b0, 10'd512,  8'hFF, 10'd10,   8'h3C, "hold10"};

    // Power-on reset.
    #1;
    check("rst_out_addr0", dout, 8'h00);
    repeat (2) @(negedge clk);
    arst = 1'b0;
    read_check("rst_out_addr1023", 10'd1023, 8'h00);

    // Table-driven vectors, one per cycle.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      addr = vecs[i].a;
      din  = vecs[i].d;
      en   = vecs[i].en;
      @(posedge clk);
      #1;
      en = 1'b0;
      if (vecs[i].en) model[vecs[i].a] = vecs[i].d;
      read_check(vecs[i].name, vecs[i].ca, vecs[i].exp);
    end

    // Enable gating: 5 edges with en low must not disturb addr 100.
    @(negedge clk);
    addr = 10'd100;
    din  = 8'hFF;
    en   = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("en_gating100", dout, 8'h00);

    // Read and write same address in one cycle: old before edge, new after.
    @(negedge clk);
    addr = 10'd1023;
    din  = 8'h11;
    en   = 1'b1;
    #1;
    check("raw_before_edge", dout, 8'hAA);
    @(posedge clk);
    #1;
    check("raw_after_edge", dout, 8'h11);
    en = 1'b0;
    model[1023] = 8'h11;

    // Random traffic, each pair held for two edges.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      a = addr_t'($urandom_range(0, DEPTH - 1));
      d = data_t'($urandom_range(0, 255));
      addr = a;
      din  = d;
      en   = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      model[a] = d;
      check("rand_pair", dout, d);
    end
    @(negedge clk);
    en = 1'b0;

    // Final sweep against the scoreboard.
    for (int k = 0; k < DEPTH; k++) begin
      read_check("sweep", addr_t'(k), model[k]);
    end

    // Reset clears all words, with the clock parked (no edges).
    do_write(10'd0, 8'hA5);
    do_write(10'd511, 8'hA5);
    do_write(10'd1023, 8'hA5);
    read_check("pre_rst_addr0", 10'd0, 8'hA5);
    read_check("pre_rst_addr511", 10'd511, 8'hA5);
    @(negedge clk);
    clk_run = 1'b0;
    arst = 1'b1;
    read_check("async_clear_1023", 10'd1023, 8'h00);
    #49;
    read_check("rst_addr0", 10'd0, 8'h00);
    read_check("rst_addr511", 10'd511, 8'h00);
    read_check("rst_addr1023", 10'd1023, 8'h00);
    for (int i = 0; i < 16; i++) begin
      ra = addr_t'($urandom_range(1, 510));
      read_check("rst_rand", ra, 8'h00);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;

    // Writes ignored while reset held with the clock running.
    addr = 10'd300;
    din  = 8'h33;
    en   = 1'b1;
    clk_run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("wr_during_rst", dout, 8'h00);

    // First edge after release performs the write.
    @(negedge clk);
    arst = 1'b0;
    din  = 8'h77;
    @(posedge clk);
    #1;
    en = 1'b0;
    check("first_wr_after_rst", dout, 8'h77);
    read_check("post_rst_addr511", 10'd511, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_column.md
# reg_column

Word-addressable storage column of 1024 × 8-bit registers with a single synchronous write port and a combinational read port. Used as a register-file/page building block, with one column per byte lane. A write on a clock edge is visible on the read port immediately after that edge. Asynchronous reset clears every entry.

## Interface
- `DATA_W`, default 8: width of each stored word.
- `ADDR_W`, default 10: address width.
- `DEPTH`, derived as `1 << ADDR_W` (1024): number of words. Not separately overridable.

- `clk_i`, input, 1: sole clock; all state updates on the rising edge.
- `arst_i`, input, 1: reset, asynchronous, active-high.
- `in`, input, `DATA_W`: write data.
- `addr`, input, `ADDR_W`: shared read/write address.
- `en_i`, input, 1: write enable, active-high.
- `out`, output, `DATA_W`: read data, equal to `mem[addr]`.

## Operation
- Storage: `mem[0 .. DEPTH-1]`, each `DATA_W` bits wide.
- Write: on the rising edge of `clk_i`, when `en_i` = 1 and `arst_i` = 0, `mem[addr] <= in`.
  - Exactly one word is written.
  - All other words hold their values.
- No write: when `en_i` = 0, all words hold.
- Read: `out = mem[addr]`, purely combinational.
  - No read enable.
  - `out` is driven at all times.
- Addressing: fully decoded. Every `addr` value is a valid entry, so there is no out-of-range case and no wrap logic.
- Reset:
  - While `arst_i` = 1, every word is forced to 0, so `out` = 0 for any `addr`.
  - Writes are ignored while reset is asserted.
  - Asserting reset mid-operation clears all contents immediately, without waiting for a clock edge.
- Release of reset: the first write can occur on the first rising edge after `arst_i` falls.
- X on `addr` or `in` while `en_i` = 0 has no effect on stored state.

## Timing
- Write latency: 1 edge. `mem[addr]` takes the new value at the rising edge where `en_i` = 1.
- Read latency: 0 cycles. `out` follows `addr` changes combinationally, and follows a write to the currently addressed word right after the edge.
- Read and write to the same address in the same cycle:
  - Before the edge, `out` shows the old value.
  - After the edge, `out` shows `in`.
- Back-to-back writes to the same address: the last written value wins. One word per cycle, no stalls.
- No handshake. The block is always ready.
- Reset timing:
  - Assertion is asynchronous.
  - Deassertion should be synchronized to `clk_i` externally.
  - Reset values: all `mem` = 0; `out` = 0.

## Structure
- Shared package `reg_column_pkg` holds:
  - `DATA_W` and `ADDR_W` constants.
  - `DEPTH` constant.
  - typedefs `data_t` (`logic [DATA_W-1:0]`) and `addr_t` (`logic [ADDR_W-1:0]`).
- Sub-module `reg_word`:
  - One `DATA_W`-bit register with async active-high reset to 0 and a load enable.
  - Instantiated `DEPTH` times via generate.
  - Load enable for word *k* = `en_i & (addr == k)`.
- Top-level read path: a `DEPTH`:1 mux of word outputs, selected by `addr`.

## Test plan
- **Reset clears all words:** write 0xA5 to addresses 0, 511 and 1023; assert `arst_i` for 50 ns without a clock edge → `out` = 0 at each of the three addresses, and at a random sample of 16 other addresses.
- **Basic write/read:** write 0x3C to `addr` 10 with `en_i` = 1 for 1 cycle → `out` = 0x3C immediately after the edge; the neighbouring addresses 9 and 11 still read 0.
- **Enable gating:** with `en_i` = 0, drive `in` = 0xFF at `addr` 100 for 5 edges → `out` at `addr` 100 stays at its previous value of 0.
- **Boundary addresses and overwrite:**
  - Write 0x01 to `addr` 0 and 0x80 to `addr` 1023 → each reads back exactly, with no aliasing.
  - Then write 0x55 and then 0xAA to `addr` 1023 on consecutive cycles → `out` = 0xAA.
- **Random traffic:** 100 cycles of random `in`/`addr` with `en_i` = 1, holding each pair for 2 edges → after each pair, `out` = `in` for that `addr`. A final sweep of all addresses matches a scoreboard model.
